// File: rtl/zap_wb_pkg.sv
// Shared types and constants for the two-master Wishbone arbiter.
// The request struct lets both master ports be muxed onto the bus as a single field.
package zap_wb_pkg;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_BURST   = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    localparam int WDOG_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        GNT0 = 2'b01,
        GNT1 = 2'b10
    } arb_state_e;

    typedef struct packed {
        logic        cyc;
        logic        stb;
        logic        we;
        logic [3:0]  sel;
        logic [2:0]  cti;
        logic [31:0] adr;
        logic [31:0] dat;
    } wb_req_t;

    // An ACK on a classic cycle or an end-of-burst beat completes the transfer.
    function automatic logic is_final_beat(input logic [2:0] cti);
        return (cti == CTI_CLASSIC) || (cti == CTI_EOB);
    endfunction

endpackage

// File: rtl/zap_wb_arb_watchdog.sv
// Stall watchdog for the arbiter: counts granted strobe cycles without an ACK and
// raises a sticky flag once TIMEOUT such cycles have accumulated.
module zap_wb_arb_watchdog
    import zap_wb_pkg::*;
#(
    parameter int TIMEOUT = 8
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_idle,
    input  logic i_stb,
    input  logic i_ack,
    output logic o_timeout
);

    localparam logic [WDOG_W-1:0] C_LIMIT = WDOG_W'(TIMEOUT);

    logic [WDOG_W-1:0] r_count;
    logic [WDOG_W-1:0] w_count_nxt;
    logic              r_timeout;

    // Saturates so a very long stall can never wrap back under the limit.
    always_comb begin
        w_count_nxt = r_count;
        if (i_idle || i_ack) begin
            w_count_nxt = '0;
        end else if (i_stb && (r_count != '1)) begin
            w_count_nxt = r_count + WDOG_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_count   <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_count   <= w_count_nxt;
            r_timeout <= r_timeout | (w_count_nxt >= C_LIMIT);
        end
    end

    assign o_timeout = r_timeout;

endmodule

// File: rtl/zap_wb_arbiter.sv
// Two-master Wishbone B3 arbiter: instruction side (m0) and data side (m1) share one bus,
// a grant is held for a whole cycle including incrementing bursts.
//
//   state | meaning
//   IDLE  | bus quiet, arbitrate among requesters for the next cycle
//   GNT0  | master 0 owns the bus until cyc drops or its final beat is ACKed
//   GNT1  | master 1 owns the bus until cyc drops or its final beat is ACKed
module zap_wb_arbiter
    import zap_wb_pkg::*;
#(
    parameter int ARB_MODE = 0,
    parameter int TIMEOUT  = 0
) (
    input  logic        i_clk,
    input  logic        i_reset_n,

    input  logic        i_m0_wb_cyc,
    input  logic        i_m0_wb_stb,
    input  logic        i_m0_wb_we,
    input  logic [3:0]  i_m0_wb_sel,
    input  logic [2:0]  i_m0_wb_cti,
    input  logic [31:0] i_m0_wb_adr,
    input  logic [31:0] i_m0_wb_dat,
    output logic [31:0] o_m0_wb_dat,
    output logic        o_m0_wb_ack,

    input  logic        i_m1_wb_cyc,
    input  logic        i_m1_wb_stb,
    input  logic        i_m1_wb_we,
    input  logic [3:0]  i_m1_wb_sel,
    input  logic [2:0]  i_m1_wb_cti,
    input  logic [31:0] i_m1_wb_adr,
    input  logic [31:0] i_m1_wb_dat,
    output logic [31:0] o_m1_wb_dat,
    output logic        o_m1_wb_ack,

    output logic        o_wb_cyc,
    output logic        o_wb_stb,
    output logic        o_wb_we,
    output logic [3:0]  o_wb_sel,
    output logic [2:0]  o_wb_cti,
    output logic [31:0] o_wb_adr,
    output logic [31:0] o_wb_dat,
    input  logic [31:0] i_wb_dat,
    input  logic        i_wb_ack,

    output logic        o_timeout,
    output logic [1:0]  o_gnt
);

    wb_req_t    w_m0;
    wb_req_t    w_m1;
    wb_req_t    w_bus;
    arb_state_e r_state;
    arb_state_e w_state_nxt;
    logic       r_last_gnt;
    logic       w_req0;
    logic       w_req1;
    logic       w_gnt0;
    logic       w_gnt1;

    assign w_m0 = {i_m0_wb_cyc, i_m0_wb_stb, i_m0_wb_we, i_m0_wb_sel,
                   i_m0_wb_cti, i_m0_wb_adr, i_m0_wb_dat};
    assign w_m1 = {i_m1_wb_cyc, i_m1_wb_stb, i_m1_wb_we, i_m1_wb_sel,
                   i_m1_wb_cti, i_m1_wb_adr, i_m1_wb_dat};

    assign w_req0 = w_m0.cyc & w_m0.stb;
    assign w_req1 = w_m1.cyc & w_m1.stb;

    // Requests seen in a release cycle are ignored; they win in the IDLE cycle that follows.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_req0 && w_req1) begin
                    w_state_nxt = ((ARB_MODE != 0) || !r_last_gnt) ? GNT1 : GNT0;
                end else if (w_req0) begin
                    w_state_nxt = GNT0;
                end else if (w_req1) begin
                    w_state_nxt = GNT1;
                end
            end
            GNT0: begin
                if (!w_m0.cyc || (i_wb_ack && w_m0.stb && is_final_beat(w_m0.cti))) begin
                    w_state_nxt = IDLE;
                end
            end
            GNT1: begin
                if (!w_m1.cyc || (i_wb_ack && w_m1.stb && is_final_beat(w_m1.cti))) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state    <= IDLE;
            r_last_gnt <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            if ((r_state == IDLE) && (w_state_nxt == GNT0)) begin
                r_last_gnt <= 1'b0;
            end else if ((r_state == IDLE) && (w_state_nxt == GNT1)) begin
                r_last_gnt <= 1'b1;
            end
        end
    end

    assign w_gnt0 = (r_state == GNT0);
    assign w_gnt1 = (r_state == GNT1);

    always_comb begin
        w_bus = '0;
        if (w_gnt0) begin
            w_bus = w_m0;
        end else if (w_gnt1) begin
            w_bus = w_m1;
        end
    end

    assign o_wb_cyc = w_bus.cyc;
    assign o_wb_stb = w_bus.stb;
    assign o_wb_we  = w_bus.we;
    assign o_wb_sel = w_bus.sel;
    assign o_wb_cti = w_bus.cti;
    assign o_wb_adr = w_bus.adr;
    assign o_wb_dat = w_bus.dat;

    assign o_m0_wb_ack = w_gnt0 & i_wb_ack & i_m0_wb_stb;
    assign o_m1_wb_ack = w_gnt1 & i_wb_ack & i_m1_wb_stb;
    assign o_m0_wb_dat = w_gnt0 ? i_wb_dat : 32'h0;
    assign o_m1_wb_dat = w_gnt1 ? i_wb_dat : 32'h0;

    assign o_gnt = {w_gnt1, w_gnt0};

    generate
        if (TIMEOUT > 0) begin : g_wdog
            zap_wb_arb_watchdog #(
                .TIMEOUT (TIMEOUT)
            ) u_wdog (
                .i_clk     (i_clk),
                .i_reset_n (i_reset_n),
                .i_idle    (r_state == IDLE),
                .i_stb     (w_bus.stb),
                .i_ack     (i_wb_ack),
                .o_timeout (o_timeout)
            );
        end else begin : g_no_wdog
            assign o_timeout = 1'b0;
        end
    endgenerate

endmodule

// File: tb/tb_zap_wb_arbiter.sv
// Bench for zap_wb_arbiter: randomized masters and slave, a spec-level grant model and
// per-master read-data scoreboards, plus directed burst, watchdog, reset and priority cases.
module tb_zap_wb_arbiter;
    import zap_wb_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
    logic [3:0]  m0_sel, m1_sel;
    logic [2:0]  m0_cti, m1_cti;
    logic [31:0] m0_adr, m0_dat, m1_adr, m1_dat;
    logic [31:0] m0_rdat, m1_rdat;
    logic        m0_ack, m1_ack;
    logic        wb_cyc, wb_stb, wb_we;
    logic [3:0]  wb_sel;
    logic [2:0]  wb_cti;
    logic [31:0] wb_adr, wb_wdat, wb_rdat;
    logic        wb_ack;
    logic        tmo;
    logic [1:0]  gnt;

    // Second instance: fixed priority, always-ACK slave.
    logic        p0_cyc, p0_stb, p1_cyc, p1_stb;
    logic [31:0] p0_rdat, p1_rdat;
    logic        p0_ack, p1_ack;
    logic        p_cyc, p_stb, p_we;
    logic [3:0]  p_sel;
    logic [2:0]  p_cti;
    logic [31:0] p_adr, p_wdat;
    logic        p_tmo;
    logic [1:0]  p_gnt;
    logic        p_wb_ack;
    assign p_wb_ack = p_cyc & p_stb;

    zap_wb_arbiter #(.ARB_MODE(0), .TIMEOUT(8)) dut (
        .i_clk(clk), .i_reset_n(rst_n),
        .i_m0_wb_cyc(m0_cyc), .i_m0_wb_stb(m0_stb), .i_m0_wb_we(m0_we), .i_m0_wb_sel(m0_sel),
        .i_m0_wb_cti(m0_cti), .i_m0_wb_adr(m0_adr), .i_m0_wb_dat(m0_dat),
        .o_m0_wb_dat(m0_rdat), .o_m0_wb_ack(m0_ack),
        .i_m1_wb_cyc(m1_cyc), .i_m1_wb_stb(m1_stb), .i_m1_wb_we(m1_we), .i_m1_wb_sel(m1_sel),
        .i_m1_wb_cti(m1_cti), .i_m1_wb_adr(m1_adr), .i_m1_wb_dat(m1_dat),
        .o_m1_wb_dat(m1_rdat), .o_m1_wb_ack(m1_ack),
        .o_wb_cyc(wb_cyc), .o_wb_stb(wb_stb), .o_wb_we(wb_we), .o_wb_sel(wb_sel),
        .o_wb_cti(wb_cti), .o_wb_adr(wb_adr), .o_wb_dat(wb_wdat),
        .i_wb_dat(wb_rdat), .i_wb_ack(wb_ack),
        .o_timeout(tmo), .o_gnt(gnt)
    );

    zap_wb_arbiter #(.ARB_MODE(1), .TIMEOUT(0)) dut_p (
        .i_clk(clk), .i_reset_n(rst_n),
        .i_m0_wb_cyc(p0_cyc), .i_m0_wb_stb(p0_stb), .i_m0_wb_we(1'b0), .i_m0_wb_sel(4'hF),
        .i_m0_wb_cti(CTI_CLASSIC), .i_m0_wb_adr(32'h0000_0100), .i_m0_wb_dat(32'h0),
        .o_m0_wb_dat(p0_rdat), .o_m0_wb_ack(p0_ack),
        .i_m1_wb_cyc(p1_cyc), .i_m1_wb_stb(p1_stb), .i_m1_wb_we(1'b0), .i_m1_wb_sel(4'hF),
        .i_m1_wb_cti(CTI_CLASSIC), .i_m1_wb_adr(32'h0000_0200), .i_m1_wb_dat(32'h0),
        .o_m1_wb_dat(p1_rdat), .o_m1_wb_ack(p1_ack),
        .o_wb_cyc(p_cyc), .o_wb_stb(p_stb), .o_wb_we(p_we), .o_wb_sel(p_sel),
        .o_wb_cti(p_cti), .o_wb_adr(p_adr), .o_wb_dat(p_wdat),
        .i_wb_dat(32'h1234_5678), .i_wb_ack(p_wb_ack),
        .o_timeout(p_tmo), .o_gnt(p_gnt)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] q0[$];
    logic [31:0] q1[$];
    bit          g_en = 0;
    bit          d_en = 0;
    bit          slv_stall = 0;

    function automatic logic [31:0] rd_data(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    function automatic logic [31:0] wr_data(input int id, input logic [31:0] a);
        return a ^ ((id == 0) ? 32'hA5A5_0000 : 32'h0000_5A5A);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input int id, input logic cyc, input logic we,
                         input logic [2:0] cti, input logic [31:0] adr);
        if (id == 0) begin
            m0_cyc = cyc; m0_stb = cyc; m0_we = we; m0_sel = adr[7:4];
            m0_cti = cti; m0_adr = adr; m0_dat = wr_data(0, adr);
        end else begin
            m1_cyc = cyc; m1_stb = cyc; m1_we = we; m1_sel = adr[7:4];
            m1_cti = cti; m1_adr = adr; m1_dat = wr_data(1, adr);
        end
    endtask

    task automatic wait_ack(input int id, output bit got);
        got = 0;
        for (int k = 0; k < 300 && !got; k++) begin
            @(negedge clk);
            got = (id == 0) ? m0_ack : m1_ack;
        end
    endtask

    // One classic cycle or a 4-beat incrementing burst; expected read data queued per beat.
    task automatic do_txn(input int id, input logic [31:0] base, input bit burst, input logic we);
        int beats;
        beats = burst ? 4 : 1;
        for (int b = 0; b < beats; b++) begin
            logic [31:0] a;
            logic [2:0]  cti;
            bit          got;
            a   = base + 32'(4 * b);
            cti = !burst ? CTI_CLASSIC : ((b == beats - 1) ? CTI_EOB : CTI_BURST);
            if (id == 0) q0.push_back(rd_data(a));
            else         q1.push_back(rd_data(a));
            drive(id, 1'b1, we, cti, a);
            wait_ack(id, got);
            if (!got) begin
                chk((id == 0) ? "m0_ack_wait" : "m1_ack_wait", 0, 1);
                drive(id, 1'b0, 1'b0, CTI_CLASSIC, 32'h0);
                return;
            end
            @(posedge clk); #1;
        end
        drive(id, 1'b0, 1'b0, CTI_CLASSIC, 32'h0);
    endtask

    task automatic master_run(input int id, input int n);
        for (int t = 0; t < n; t++) begin
            logic [31:0] base;
            base = ((id == 0) ? 32'h0000_1000 : 32'h0000_8000) + (32'($urandom_range(0, 255)) << 4);
            do_txn(id, base, $urandom_range(0, 2) == 0, 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk); #1;
            end
        end
    endtask

    // Grant model: IDLE picks from the requests it saw (round robin, M0 first after reset);
    // a grant drops to IDLE after a cycle where cyc fell or a final beat was ACKed.
    task automatic monitor_loop();
        logic [1:0] pg = 2'b00;
        logic [1:0] eg;
        bit         last = 1;
        bit         pr0 = 0, pr1 = 0, prel0 = 0, prel1 = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pg = 2'b00; last = 1; pr0 = 0; pr1 = 0;
            end else begin
                if (pg == 2'b00) begin
                    if (pr0 && pr1) eg = last ? 2'b01 : 2'b10;
                    else if (pr0)   eg = 2'b01;
                    else if (pr1)   eg = 2'b10;
                    else            eg = 2'b00;
                    if (eg != 2'b00) last = (eg == 2'b10);
                end else if (pg == 2'b01) begin
                    eg = prel0 ? 2'b00 : 2'b01;
                end else begin
                    eg = prel1 ? 2'b00 : 2'b10;
                end
                if (g_en) begin
                    chk("grant", gnt, eg);
                    if (gnt != 2'b01) chk("m0_isolation", {m0_ack, m0_rdat}, 0);
                    if (gnt != 2'b10) chk("m1_isolation", {m1_ack, m1_rdat}, 0);
                    if (gnt == 2'b01) begin
                        chk("bus_ctl_m0", {wb_cyc, wb_stb, wb_we, wb_sel, wb_cti},
                            {m0_cyc, m0_stb, m0_we, m0_sel, m0_cti});
                        chk("bus_adr_m0", wb_adr, m0_adr);
                    end else if (gnt == 2'b10) begin
                        chk("bus_ctl_m1", {wb_cyc, wb_stb, wb_we, wb_sel, wb_cti},
                            {m1_cyc, m1_stb, m1_we, m1_sel, m1_cti});
                        chk("bus_adr_m1", wb_adr, m1_adr);
                    end else begin
                        chk("bus_idle", {wb_cyc, wb_stb, wb_we, wb_sel, wb_cti, wb_adr}, 0);
                    end
                    if (wb_ack && wb_we && (gnt != 2'b00))
                        chk("wdata", wb_wdat, wr_data((gnt == 2'b10) ? 1 : 0, wb_adr));
                end
                if (d_en) begin
                    if (m0_ack) begin
                        if (q0.size() == 0) chk("m0_unexpected_ack", 1, 0);
                        else                chk("m0_rdata", m0_rdat, q0.pop_front());
                    end
                    if (m1_ack) begin
                        if (q1.size() == 0) chk("m1_unexpected_ack", 1, 0);
                        else                chk("m1_rdata", m1_rdat, q1.pop_front());
                    end
                end
                pr0   = m0_cyc & m0_stb;
                pr1   = m1_cyc & m1_stb;
                prel0 = !m0_cyc || (wb_ack && m0_stb && (m0_cti == CTI_CLASSIC || m0_cti == CTI_EOB));
                prel1 = !m1_cyc || (wb_ack && m1_stb && (m1_cti == CTI_CLASSIC || m1_cti == CTI_EOB));
                pg    = eg;
            end
        end
    endtask

    // Slave: 0-2 wait states per beat, junk on the data bus whenever it is not ACKing.
    initial begin
        int wcnt;
        wcnt    = 0;
        wb_ack  = 1'b0;
        wb_rdat = 32'h0;
        forever begin
            @(posedge clk); #2;
            if (!rst_n || slv_stall || !(wb_cyc && wb_stb)) begin
                wb_ack  = 1'b0;
                wb_rdat = $urandom();
            end else if (wcnt == 0) begin
                wb_ack  = 1'b1;
                wb_rdat = rd_data(wb_adr);
                wcnt    = $urandom_range(0, 2);
            end else begin
                wb_ack  = 1'b0;
                wb_rdat = $urandom();
                wcnt--;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: actual=running required=finished");
        $fatal(1, "bench did not finish");
    end

    initial begin
        logic [1:0] seq[$];
        logic [1:0] prev_obs;
        bit         got;
        int         g1, m0_won, p1_acks;

        rst_n = 1'b0;
        drive(0, 1'b0, 1'b0, CTI_CLASSIC, 32'h0);
        drive(1, 1'b0, 1'b0, CTI_CLASSIC, 32'h0);
        p0_cyc = 0; p0_stb = 0; p1_cyc = 0; p1_stb = 0;
        #1;
        chk("rst_gnt", gnt, 0);
        chk("rst_bus", {wb_cyc, wb_stb, wb_we, wb_sel, wb_cti, wb_adr}, 0);
        chk("rst_bus_dat", wb_wdat, 0);
        chk("rst_masters", {m0_ack, m1_ack, m0_rdat, m1_rdat}, 0);
        chk("rst_timeout", tmo, 0);
        chk("rst_p_gnt", p_gnt, 0);
        fork monitor_loop(); join_none
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;

        // Round robin with both masters requesting continuously: M0, M1, M0, ...
        @(posedge clk); #1;
        g_en = 1;
        drive(0, 1'b1, 1'b0, CTI_CLASSIC, 32'h0000_0100);
        drive(1, 1'b1, 1'b0, CTI_CLASSIC, 32'h0000_0200);
        prev_obs = 2'b00;
        for (int c = 0; c < 200 && seq.size() < 6; c++) begin
            @(negedge clk);
            if (gnt != 2'b00 && prev_obs == 2'b00) seq.push_back(gnt);
            prev_obs = gnt;
        end
        chk("rr_grant_count", seq.size(), 6);
        for (int i = 0; i < seq.size(); i++)
            chk("rr_order", seq[i], (i % 2 == 0) ? 2'b01 : 2'b10);
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, CTI_CLASSIC, 32'h0);
        drive(1, 1'b0, 1'b0, CTI_CLASSIC, 32'h0);
        repeat (3) @(posedge clk);
        #1;

        // Random traffic from both masters.
        d_en = 1;
        fork
            master_run(0, 30);
            master_run(1, 30);
        join
        repeat (3) @(negedge clk);
        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);
        chk("no_timeout_yet", tmo, 0);

        // M1 burst holds the bus against M0; M0 granted two cycles after the 4th ACK.
        @(posedge clk); #1;
        fork
            do_txn(1, 32'h0000_2000, 1'b1, 1'b0);
            begin
                repeat (2) @(posedge clk);
                #1;
                do_txn(0, 32'h0000_0100, 1'b0, 1'b0);
            end
            begin
                int acks, k;
                bit done;
                acks = 0; k = 0; done = 0;
                for (int c = 0; c < 300 && !done; c++) begin
                    @(negedge clk);
                    if (acks == 4) begin
                        k++;
                        if (gnt == 2'b01) done = 1;
                    end else if (m1_ack) begin
                        acks++;
                    end
                end
                chk("gnt0_after_burst", k, 2);
            end
        join

        // Watchdog: stalled write, flag after the 8th stalled cycle, sticky past the ACK.
        @(posedge clk); #1;
        slv_stall = 1;
        fork
            do_txn(0, 32'h0000_0040, 1'b0, 1'b1);
            begin
                bit seen;
                seen = 0;
                for (int c = 0; c < 20 && !seen; c++) begin
                    @(negedge clk);
                    seen = (gnt == 2'b01);
                end
                chk("wd_grant_seen", seen, 1);
                repeat (7) @(negedge clk);
                chk("wd_before_limit", tmo, 0);
                @(negedge clk);
                chk("wd_at_limit", tmo, 1);
                chk("wd_grant_held", gnt, 2'b01);
                slv_stall = 0;
            end
        join
        repeat (2) @(negedge clk);
        chk("wd_sticky", tmo, 1);
        chk("q0_drained_wd", q0.size(), 0);

        // Reset in the middle of beat 2 of an M1 burst.
        g_en = 0; d_en = 0;
        @(posedge clk); #1;
        drive(1, 1'b1, 1'b0, CTI_BURST, 32'h0000_3000);
        wait_ack(1, got);
        chk("rb_beat1", got, 1);
        @(posedge clk); #1;
        drive(1, 1'b1, 1'b0, CTI_BURST, 32'h0000_3004);
        wait_ack(1, got);
        chk("rb_beat2", got, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("rb_m1_ack", {m1_ack, m1_rdat}, 0);
        chk("rb_m0_ack", {m0_ack, m0_rdat}, 0);
        chk("rb_bus", {wb_cyc, wb_stb, wb_we, wb_sel, wb_cti, wb_adr}, 0);
        chk("rb_gnt", gnt, 0);
        chk("rb_timeout", tmo, 0);
        drive(0, 1'b1, 1'b0, CTI_CLASSIC, 32'h0000_0500);
        drive(1, 1'b1, 1'b0, CTI_CLASSIC, 32'h0000_0600);
        @(negedge clk);
        #1 rst_n = 1'b1;
        chk("rb_idle_after", gnt, 0);
        @(negedge clk);
        chk("rb_first_grant", gnt, 2'b01);
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, CTI_CLASSIC, 32'h0);
        drive(1, 1'b0, 1'b0, CTI_CLASSIC, 32'h0);

        // Fixed priority instance: M1 wins every arbitration while it requests.
        @(posedge clk); #1;
        p0_cyc = 1; p0_stb = 1; p1_cyc = 1; p1_stb = 1;
        g1 = 0; m0_won = 0; p1_acks = 0; prev_obs = 2'b00;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (p_gnt == 2'b01) m0_won++;
            if (p_gnt == 2'b10 && prev_obs != 2'b10) g1++;
            if (p1_ack) p1_acks++;
            chk("p_m0_no_ack", {p0_ack, p0_rdat}, 0);
            prev_obs = p_gnt;
        end
        chk("p_gnt1_count", g1, 10);
        chk("p_m0_never", m0_won, 0);
        chk("p_m1_acks", p1_acks, 10);
        @(posedge clk); #1;
        p1_cyc = 0; p1_stb = 0;
        got = 0;
        for (int c = 0; c < 4 && !got; c++) begin
            @(negedge clk);
            got = (p_gnt == 2'b01);
        end
        chk("p_m0_after_m1_idle", got, 1);
        p0_cyc = 0; p0_stb = 0;
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
